// File: rtl/gtp_tx_framer.sv
// gtp_tx_framer: TX link-layer framer for a 2-byte 8b10b GTP lane.
// Packs a valid/ready word stream into SOF / payload / CRC-16 / EOF frames.
// Idle commas fill every gap, and over-long or link-lost frames are aborted.
module gtp_tx_framer #(
    parameter int unsigned MAX_PAYLOAD = 256,
    parameter int unsigned MIN_IDLE    = 4
) (
    input  logic        tx_clk,
    input  logic        reset,
    input  logic        link_ready,
    input  logic [15:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    output logic [15:0] tx_data,
    output logic [1:0]  txcharisk,
    output logic        frame_sent,
    output logic        frame_err
);

    // Code words; byte 0 ([7:0]) goes on the wire first.
    localparam logic [15:0] IdleWord  = 16'h50BC;  // K28.5, D16.2
    localparam logic [7:0]  SofChar   = 8'hFB;     // K27.7, seq in byte 1
    localparam logic [15:0] EofWord   = 16'hFDFD;  // K29.7 x2
    localparam logic [15:0] AbortWord = 16'hFEFE;  // K30.7 x2
    localparam logic [1:0]  KIdle     = 2'b01;
    localparam logic [1:0]  KBoth     = 2'b11;
    localparam logic [1:0]  KNone     = 2'b00;

    localparam logic [16:0] MaxPayload = 17'(MAX_PAYLOAD);
    localparam logic [7:0]  MinIdle    = 8'(MIN_IDLE);

    typedef enum logic [2:0] {
        StIdle,
        StSof,
        StData,
        StCrc,
        StEof,
        StAbort,
        StDrop,
        StGap
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] crc_q, crc_d;
    logic        abort_pend_q, abort_pend_d;   // frame hit MAX_PAYLOAD: CRC then ABORT
    logic        tail_pend_q, tail_pend_d;     // s_tlast not yet consumed for this frame
    logic [15:0] tx_data_q, tx_data_d;
    logic [1:0]  txcharisk_q, txcharisk_d;
    logic        frame_sent_q, frame_sent_d;
    logic        frame_err_q, frame_err_d;

    logic        accept;
    logic [16:0] cnt_inc;

    // CRC-16/CCITT-FALSE over one 16-bit word, bit 15 first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Ready depends only on state and link_ready, so producers see it without a cycle of lag.
    assign s_tready = (state_q == StData && link_ready) || (state_q == StDrop);
    assign accept   = s_tvalid && s_tready;
    assign cnt_inc  = {1'b0, cnt_q} + 17'd1;

    // Next-state and next-output: each state computes the word shown on tx_data next cycle.
    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        gap_cnt_d    = gap_cnt_q;
        cnt_d        = cnt_q;
        crc_d        = crc_q;
        abort_pend_d = abort_pend_q;
        tail_pend_d  = tail_pend_q;
        tx_data_d    = IdleWord;
        txcharisk_d  = KIdle;
        frame_sent_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (link_ready && s_tvalid && gap_cnt_q == 8'd0) begin
                    state_d = StSof;
                end
            end

            StSof: begin
                tx_data_d    = {seq_q, SofChar};
                txcharisk_d  = KIdle;
                crc_d        = 16'hFFFF;
                cnt_d        = 16'd0;
                abort_pend_d = 1'b0;
                tail_pend_d  = 1'b1;
                // A link drop during SOF lets the SOF finish, then aborts.
                state_d      = link_ready ? StData : StAbort;
            end

            StData: begin
                if (!link_ready) begin
                    tx_data_d   = AbortWord;
                    txcharisk_d = KBoth;
                    frame_err_d = 1'b1;
                    seq_d       = seq_q + 8'd1;
                    state_d     = StDrop;
                end else if (s_tvalid) begin
                    tx_data_d   = s_tdata;
                    txcharisk_d = KNone;
                    crc_d       = crc16_word(crc_q, s_tdata);
                    cnt_d       = cnt_inc[15:0];
                    if (s_tlast) begin
                        tail_pend_d = 1'b0;
                        state_d     = StCrc;
                    end else if (cnt_inc == MaxPayload) begin
                        // Frame too long: close it with a CRC, then abort and drain the rest.
                        abort_pend_d = 1'b1;
                        state_d      = StCrc;
                    end
                end
                // No valid word: the default IDLE fill goes out and CRC/count stay put.
            end

            StCrc: begin
                tx_data_d   = crc_q;
                txcharisk_d = KNone;
                state_d     = (abort_pend_q || !link_ready) ? StAbort : StEof;
            end

            StEof: begin
                tx_data_d    = EofWord;
                txcharisk_d  = KBoth;
                frame_sent_d = 1'b1;
                seq_d        = seq_q + 8'd1;
                gap_cnt_d    = MinIdle;
                state_d      = StGap;
            end

            StAbort: begin
                tx_data_d   = AbortWord;
                txcharisk_d = KBoth;
                frame_err_d = 1'b1;
                seq_d       = seq_q + 8'd1;
                if (tail_pend_q) begin
                    state_d = StDrop;
                end else begin
                    // The tail was already consumed, so there is nothing left to drain.
                    gap_cnt_d = MinIdle;
                    state_d   = StGap;
                end
            end

            StDrop: begin
                if (accept && s_tlast) begin
                    gap_cnt_d = MinIdle;
                    state_d   = StGap;
                end
            end

            StGap: begin
                if (gap_cnt_q <= 8'd1) begin
                    // Last gap idle: start the next SOF directly so the wire sees exactly
                    // MIN_IDLE idles between EOF and SOF.
                    gap_cnt_d = 8'd0;
                    state_d   = (link_ready && s_tvalid) ? StSof : StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame without an EOF.
    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            seq_q        <= 8'd0;
            gap_cnt_q    <= 8'd0;
            cnt_q        <= 16'd0;
            crc_q        <= 16'hFFFF;
            abort_pend_q <= 1'b0;
            tail_pend_q  <= 1'b0;
            tx_data_q    <= IdleWord;
            txcharisk_q  <= KIdle;
            frame_sent_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            gap_cnt_q    <= gap_cnt_d;
            cnt_q        <= cnt_d;
            crc_q        <= crc_d;
            abort_pend_q <= abort_pend_d;
            tail_pend_q  <= tail_pend_d;
            tx_data_q    <= tx_data_d;
            txcharisk_q  <= txcharisk_d;
            frame_sent_q <= frame_sent_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign txcharisk  = txcharisk_q;
    assign frame_sent = frame_sent_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_gtp_tx_framer.sv
// tb_gtp_tx_framer: directed bench for gtp_tx_framer (MAX_PAYLOAD=4, MIN_IDLE=4).
// Each step compares {frame_sent, frame_err, s_tready, txcharisk, tx_data} after a negedge.
module tb_gtp_tx_framer;

    localparam logic [15:0] Idle  = 16'h50BC;
    localparam logic [15:0] Eof   = 16'hFDFD;
    localparam logic [15:0] Abort = 16'hFEFE;

    logic        tx_clk = 1'b0;
    logic        reset;
    logic        link_ready;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [15:0] tx_data;
    logic [1:0]  txcharisk;
    logic        frame_sent;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] crc3;
    logic [15:0] crc4;
    logic [7:0]  seq_exp;

    gtp_tx_framer #(
        .MAX_PAYLOAD(4),
        .MIN_IDLE   (4)
    ) dut (
        .tx_clk    (tx_clk),
        .reset     (reset),
        .link_ready(link_ready),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .tx_data   (tx_data),
        .txcharisk (txcharisk),
        .frame_sent(frame_sent),
        .frame_err (frame_err)
    );

    always #5 tx_clk = ~tx_clk;

    // Byte-wise CRC-16/CCITT-FALSE reference (high byte of each word first).
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] w);
        return crc_byte(crc_byte(c, w[15:8]), w[7:0]);
    endfunction

    task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait one cycle, then compare all outputs.
    task automatic exp_out(input string tag, input logic [15:0] d, input logic [1:0] k,
                           input logic rdy, input logic sent, input logic err);
        @(negedge tx_clk);
        chk(tag, {frame_sent, frame_err, s_tready, txcharisk, tx_data}, {sent, err, rdy, k, d});
    endtask

    initial begin
        crc3 = crc_word(crc_word(crc_word(16'hFFFF, 16'h1234), 16'h5678), 16'h9ABC);
        crc4 = crc_word(crc_word(crc_word(crc_word(16'hFFFF, 16'hA001), 16'hA002),
                                 16'hA003), 16'hA004);

        reset      = 1'b1;
        link_ready = 1'b1;
        s_tvalid   = 1'b0;
        s_tdata    = 16'h0000;
        s_tlast    = 1'b0;

        // Reset values and idle line with no traffic.
        @(negedge tx_clk);
        chk("reset_vals", {frame_sent, frame_err, s_tready, txcharisk, tx_data},
            {1'b0, 1'b0, 1'b0, 2'b01, Idle});
        reset = 1'b0;
        for (int i = 0; i < 3; i++) exp_out("idle_no_traffic", Idle, 2'b01, 1'b0, 1'b0, 1'b0);

        // 3-word frame, all valid.
        s_tvalid = 1'b1; s_tdata = 16'h1234; s_tlast = 1'b0;
        exp_out("t2_pre_sof", Idle, 2'b01, 1'b0, 1'b0, 1'b0);
        exp_out("t2_sof", 16'h00FB, 2'b01, 1'b1, 1'b0, 1'b0);
        exp_out("t2_d0", 16'h1234, 2'b00, 1'b1, 1'b0, 1'b0);
        s_tdata = 16'h5678;
        exp_out("t2_d1", 16'h5678, 2'b00, 1'b1, 1'b0, 1'b0);
        s_tdata = 16'h9ABC; s_tlast = 1'b1;
        exp_out("t2_d2", 16'h9ABC, 2'b00, 1'b0, 1'b0, 1'b0);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        exp_out("t2_crc", crc3, 2'b00, 1'b0, 1'b0, 1'b0);
        exp_out("t2_eof", Eof, 2'b11, 1'b0, 1'b1, 1'b0);

        // Same frame with two fill cycles; next frame pending so the gap is exact.
        s_tvalid = 1'b1; s_tdata = 16'h1234;
        for (int i = 0; i < 4; i++) exp_out("t3_gap", Idle, 2'b01, 1'b0, 1'b0, 1'b0);
        exp_out("t3_sof", 16'h01FB, 2'b01, 1'b1, 1'b0, 1'b0);
        exp_out("t3_d0", 16'h1234, 2'b00, 1'b1, 1'b0, 1'b0);
        s_tvalid = 1'b0;
        exp_out("t3_fill0", Idle, 2'b01, 1'b1, 1'b0, 1'b0);
        exp_out("t3_fill1", Idle, 2'b01, 1'b1, 1'b0, 1'b0);
        s_tvalid = 1'b1; s_tdata = 16'h5678;
        exp_out("t3_d1", 16'h5678, 2'b00, 1'b1, 1'b0, 1'b0);
        s_tdata = 16'h9ABC; s_tlast = 1'b1;
        exp_out("t3_d2", 16'h9ABC, 2'b00, 1'b0, 1'b0, 1'b0);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        exp_out("t3_crc", crc3, 2'b00, 1'b0, 1'b0, 1'b0);
        exp_out("t3_eof", Eof, 2'b11, 1'b0, 1'b1, 1'b0);

        // 6-word frame against MAX_PAYLOAD=4: 4 DATA, CRC, ABORT, drain 2 words.
        s_tvalid = 1'b1; s_tdata = 16'hA001;
        for (int i = 0; i < 4; i++) exp_out("t4_gap", Idle, 2'b01, 1'b0, 1'b0, 1'b0);
        exp_out("t4_sof", 16'h02FB, 2'b01, 1'b1, 1'b0, 1'b0);
        exp_out("t4_d0", 16'hA001, 2'b00, 1'b1, 1'b0, 1'b0);
        s_tdata = 16'hA002;
        exp_out("t4_d1", 16'hA002, 2'b00, 1'b1, 1'b0, 1'b0);
        s_tdata = 16'hA003;
        exp_out("t4_d2", 16'hA003, 2'b00, 1'b1, 1'b0, 1'b0);
        s_tdata = 16'hA004;
        exp_out("t4_d3", 16'hA004, 2'b00, 1'b0, 1'b0, 1'b0);
        s_tdata = 16'hA005;
        exp_out("t4_crc", crc4, 2'b00, 1'b0, 1'b0, 1'b0);
        exp_out("t4_abort", Abort, 2'b11, 1'b1, 1'b0, 1'b1);
        exp_out("t4_drop0", Idle, 2'b01, 1'b1, 1'b0, 1'b0);
        s_tdata = 16'hA006; s_tlast = 1'b1;
        exp_out("t4_drop1", Idle, 2'b01, 1'b0, 1'b0, 1'b0);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        for (int i = 0; i < 6; i++) exp_out("t4_idle", Idle, 2'b01, 1'b0, 1'b0, 1'b0);

        // link_ready drops after the 2nd DATA word.
        s_tvalid = 1'b1; s_tdata = 16'hB001;
        exp_out("t5_pre_sof", Idle, 2'b01, 1'b0, 1'b0, 1'b0);
        exp_out("t5_sof", 16'h03FB, 2'b01, 1'b1, 1'b0, 1'b0);
        exp_out("t5_d0", 16'hB001, 2'b00, 1'b1, 1'b0, 1'b0);
        s_tdata = 16'hB002;
        exp_out("t5_d1", 16'hB002, 2'b00, 1'b1, 1'b0, 1'b0);
        link_ready = 1'b0; s_tdata = 16'hB003;
        #1;
        chk("t5_ready_low", {frame_sent, frame_err, s_tready, txcharisk, tx_data},
            {1'b0, 1'b0, 1'b0, 2'b00, 16'hB002});
        exp_out("t5_abort", Abort, 2'b11, 1'b1, 1'b0, 1'b1);
        exp_out("t5_drop0", Idle, 2'b01, 1'b1, 1'b0, 1'b0);
        s_tdata = 16'hB004; s_tlast = 1'b1;
        exp_out("t5_drop1", Idle, 2'b01, 1'b0, 1'b0, 1'b0);
        s_tdata = 16'hC001; s_tlast = 1'b0;
        for (int i = 0; i < 8; i++) exp_out("t5_no_sof", Idle, 2'b01, 1'b0, 1'b0, 1'b0);
        link_ready = 1'b1;
        exp_out("t5_pre_sof2", Idle, 2'b01, 1'b0, 1'b0, 1'b0);
        exp_out("t5_sof2", 16'h04FB, 2'b01, 1'b1, 1'b0, 1'b0);
        exp_out("t5_c0", 16'hC001, 2'b00, 1'b1, 1'b0, 1'b0);

        // Reset in mid-frame returns everything to reset values at once.
        reset = 1'b1; s_tvalid = 1'b0;
        #1;
        chk("reset_mid_frame", {frame_sent, frame_err, s_tready, txcharisk, tx_data},
            {1'b0, 1'b0, 1'b0, 2'b01, Idle});
        @(negedge tx_clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) exp_out("post_reset_idle", Idle, 2'b01, 1'b0, 1'b0, 1'b0);

        // 257 back-to-back 1-word frames; seq restarts at 0 after reset and wraps on #257.
        s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = 16'h0000;
        seq_exp = 8'd0;
        exp_out("t6_pre_sof", Idle, 2'b01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 257; i++) begin
            exp_out((i == 256) ? "t6_sof_wrap" : "t6_sof", {seq_exp, 8'hFB}, 2'b01,
                    1'b1, 1'b0, 1'b0);
            exp_out("t6_data", 16'(i), 2'b00, 1'b0, 1'b0, 1'b0);
            s_tdata = 16'(i + 1);
            if (i == 256) s_tvalid = 1'b0;
            exp_out("t6_crc", crc_word(16'hFFFF, 16'(i)), 2'b00, 1'b0, 1'b0, 1'b0);
            exp_out("t6_eof", Eof, 2'b11, 1'b0, 1'b1, 1'b0);
            for (int j = 0; j < 4; j++) exp_out("t6_gap", Idle, 2'b01, 1'b0, 1'b0, 1'b0);
            seq_exp = seq_exp + 8'd1;
        end
        exp_out("t6_final_idle", Idle, 2'b01, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
